// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and counter sizing for serial_addsub
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(input int w, input int d);
    return (w / d > 1) ? $clog2(w / d) : 1;
  endfunction
endpackage

// File: rtl/serial_addsub_fa_cell.sv
// fa_cell: one full-adder bit; ports a, b, cin -> sum, cout
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial add/sub, DIGIT bits per cycle, LSB digit first.
// Ports: clk, rst_n (async low); in_valid/in_ready with a, b, cin, sub;
// out_valid/out_ready with sum, cout (carry or borrow), overflow; busy.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("serial_addsub: DIGIT must be in 1..WIDTH and divide WIDTH");
  end
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_sub, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_s;
  logic [DIGIT:0]   w_c;
  logic             w_last;
  assign w_c[0] = r_carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_cell u_fa (.a(r_a[i]), .b(r_b[i]), .cin(w_c[i]), .sum(w_s[i]), .cout(w_c[i+1]));
  end
  assign w_last = r_cnt == CW'(N - 1);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && in_valid) w_next = RUN;
    else if (r_state == RUN && w_last) w_next = DONE;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Subtraction is a + ~b + ~cin; the final carry is then the inverted borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_sub   <= sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= WIDTH'({w_s, r_sum} >> DIGIT);
      r_carry <= w_c[DIGIT];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= r_sub ^ w_c[DIGIT];
        r_ovf  <= w_c[DIGIT-1] ^ w_c[DIGIT];
      end
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: self-checking bench for serial_addsub with DIGIT=1 and DIGIT=4
module tb_serial_addsub;
  logic clk = 1'b0, rst_n = 1'b0;
  logic iv = 1'b0, ordy = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  int dsel = 1;
  int passed = 0, total = 0;
  logic ir1, ov1, co1, of1, bz1, ir4, ov4, co4, of4, bz4;
  logic [7:0] s1, s4;
  logic iv1, iv4, or1, or4, ir, ov, co, of, bz;
  logic [7:0] s;
  assign iv1 = iv && dsel == 1;
  assign iv4 = iv && dsel == 4;
  assign or1 = ordy && dsel == 1;
  assign or4 = ordy && dsel == 4;
  assign ir = dsel == 4 ? ir4 : ir1;
  assign ov = dsel == 4 ? ov4 : ov1;
  assign co = dsel == 4 ? co4 : co1;
  assign of = dsel == 4 ? of4 : of1;
  assign bz = dsel == 4 ? bz4 : bz1;
  assign s  = dsel == 4 ? s4 : s1;
  always #5 clk = ~clk;
  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .overflow(of1), .busy(bz1));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .overflow(of4), .busy(bz4));
  // Reference: {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c, input logic sb);
    int ua, ub, sa, sbb, ci, u, sg;
    ua = x; ub = y; sa = $signed(x); sbb = $signed(y); ci = c;
    u  = sb ? ua - ub - ci : ua + ub + ci;
    sg = sb ? sa - sbb - ci : sa + sbb + ci;
    return {sg > 127 || sg < -128, sb ? u < 0 : u > 255, 8'(u)};
  endfunction
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic c, input logic sb,
                       input int hold, output logic [9:0] res, output int lat);
    int w = 0;
    @(negedge clk);
    while (!ir && w < 20) begin @(negedge clk); w++; end
    a = x; b = y; cin = c; sub = sb; iv = 1'b1; ordy = 1'b0;
    @(posedge clk); #1;
    iv = 1'b0; a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
    lat = 0;
    while (!ov && lat < 100) begin @(posedge clk); #1; lat++; end
    res = {of, co, s};
    repeat (hold) @(posedge clk);
    @(negedge clk); ordy = 1'b1;
    @(posedge clk); #1; ordy = 1'b0;
  endtask
  task automatic test_reset;
    dsel = 1; #1;
    total++; if ({ir, ov, bz} !== 3'b100) $display("FAIL reset_flags got %b want 100", {ir, ov, bz}); else passed++;
    total++; if ({of, co, s} !== 10'h0) $display("FAIL reset_outputs got %h want 000", {of, co, s}); else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_vec(input string nm, input int d, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input logic sb, input logic [9:0] want);
    logic [9:0] r; int lat;
    dsel = d;
    do_op(x, y, c, sb, 0, r, lat);
    total++; if (r !== want) $display("FAIL %s got %h want %h", nm, r, want); else passed++;
    total++; if (lat != 8 / d) $display("FAIL %s_latency got %0d want %0d", nm, lat, 8 / d); else passed++;
  endtask
  task automatic test_add;
    test_vec("add_5a_3c", 1, 8'h5A, 8'h3C, 1'b0, 1'b0, {1'b1, 1'b0, 8'h96});
    test_vec("add_wrap", 1, 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    test_vec("add_cin", 1, 8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 8'h01});
  endtask
  task automatic test_sub;
    test_vec("sub_borrow", 1, 8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b1, 8'hF0});
    test_vec("sub_ovf", 1, 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b0, 8'h7F});
  endtask
  task automatic test_digit4;
    test_vec("d4_wrap", 4, 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    test_vec("d4_sub", 4, 8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b0, 8'h7F});
  endtask
  task automatic test_backpressure;
    logic [9:0] want; int lat = 0;
    dsel = 1; want = model(8'hC3, 8'h5E, 1'b1, 1'b0);
    @(negedge clk); a = 8'hC3; b = 8'h5E; cin = 1'b1; sub = 1'b0; iv = 1'b1; ordy = 1'b0;
    @(posedge clk); #1; iv = 1'b0;
    while (!ov && lat < 100) begin @(posedge clk); #1; lat++; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); iv = k[0]; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      total++;
      if ({ov, ir, of, co, s} !== {2'b10, want})
        $display("FAIL hold_%0d got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h", k, ov, ir, {of, co, s}, want);
      else passed++;
    end
    @(negedge clk); iv = 1'b0; ordy = 1'b1;
    @(posedge clk); #1; ordy = 1'b0;
    total++; if ({ov, ir, bz} !== 3'b010) $display("FAIL consume got ov/ir/busy=%b want 010", {ov, ir, bz}); else passed++;
    total++; if ({of, co, s} !== want) $display("FAIL idle_hold got %h want %h", {of, co, s}, want); else passed++;
  endtask
  task automatic test_reset_mid_run;
    dsel = 1;
    @(negedge clk); a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0; iv = 1'b1;
    @(posedge clk); #1; iv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    total++; if ({ir, ov, bz} !== 3'b100) $display("FAIL midrun_flags got %b want 100", {ir, ov, bz}); else passed++;
    total++; if ({of, co, s} !== 10'h0) $display("FAIL midrun_outputs got %h want 000", {of, co, s}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    test_vec("after_reset", 1, 8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h02});
  endtask
  task automatic test_back_to_back;
    logic [9:0] r, want; int lat; logic [7:0] x, y; logic c, sb;
    for (int n = 0; n < 60; n++) begin
      dsel = n < 30 ? 1 : 4;
      x = $urandom; y = $urandom; c = $urandom; sb = $urandom;
      want = model(x, y, c, sb);
      do_op(x, y, c, sb, $urandom_range(0, 2), r, lat);
      total++;
      if (r !== want || lat != 8 / dsel)
        $display("FAIL rand_%0d d=%0d a=%h b=%h cin=%b sub=%b got %h lat %0d want %h lat %0d",
                 n, dsel, x, y, c, sb, r, lat, want, 8 / dsel);
      else passed++;
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_backpressure;
    test_reset_mid_run;
    test_digit4;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
